// File: rtl/cpu24_pkg.sv
// ---------------------------------------------------------------------------
// cpu24_pkg
// Shared definitions for the blocks that sit beside cpu24multi.
//   DATA_WIDTH_DEFAULT : width of the CPU result register
//   snap_state_t       : capture/stream phases of the snapshot argmax unit
//   idx_width_ok()     : elaboration-time sanity check that an index width
//                        can address every entry of a set
// ---------------------------------------------------------------------------
package cpu24_pkg;

    localparam int DATA_WIDTH_DEFAULT = 24;

    localparam int N_CLASSES_MAX = 64;

    // COLLECT fills the set from CPU strobes; STREAM drains it to the host
    typedef enum logic {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } snap_state_t;

    // An index of width w must reach entry n-1, and the set size is bounded
    // so the count register never needs more than IDX_WIDTH+1 bits.
    function automatic bit idx_width_ok(input int n, input int w);
        return (n >= 1) && (n <= N_CLASSES_MAX) && (w >= 1) && (w >= $clog2(n));
    endfunction

endpackage

// File: rtl/snapshot_mem.sv
// ---------------------------------------------------------------------------
// snapshot_mem
// N_CLASSES x DATA_WIDTH register array holding one captured set.
//   clk   : system clock
//   we    : write enable
//   waddr : write index
//   wdata : value written at waddr
//   raddr : read index
//   rdata : combinational read of entry raddr (0 for an out-of-range index)
// Storage has no reset; its contents are meaningless until written.
// ---------------------------------------------------------------------------
module snapshot_mem #(
    parameter int DATA_WIDTH = 24,
    parameter int N_CLASSES  = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [N_CLASSES];

    // Single write port; out-of-range addresses are ignored so a
    // non-power-of-two set never writes past the array.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < N_CLASSES)) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the stream port can present mem[ptr] in the
    // same cycle the pointer moves.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < N_CLASSES) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/snapshot_argmax_unit.sv
// ---------------------------------------------------------------------------
// snapshot_argmax_unit
// Records the CPU result register on each notifier strobe, keeps a running
// argmax (lowest index wins ties), then streams the stored set out over a
// valid/ready port.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous clear, same effect as rst
//   cap_strobe    : CPU notifier; cap_data is sampled on a capture event
//   cap_data      : value to capture
//   done          : full set captured, argmax outputs valid
//   argmax_idx/val: registered result of the last completed set
//   count         : entries captured in the current set
//   overflow      : sticky, a capture event arrived while streaming
//   rd_valid/rd_ready/rd_data/rd_index/rd_last : stream port
// ---------------------------------------------------------------------------
module snapshot_argmax_unit
    import cpu24_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int N_CLASSES   = 10,
    parameter int IDX_WIDTH   = 4,
    parameter int SIGNED      = 1,
    parameter int EDGE_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cap_strobe,
    input  logic [DATA_WIDTH-1:0] cap_data,
    output logic                  done,
    output logic [IDX_WIDTH-1:0]  argmax_idx,
    output logic [DATA_WIDTH-1:0] argmax_val,
    output logic [IDX_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [IDX_WIDTH-1:0]  rd_index,
    output logic                  rd_last
);

    // Reject parameter sets whose index cannot address the whole set
    if (!idx_width_ok(N_CLASSES, IDX_WIDTH)) begin : g_bad_params
        $error("snapshot_argmax_unit: IDX_WIDTH too small for N_CLASSES");
    end

    localparam logic [IDX_WIDTH:0]   CNT_ONE    = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH:0]   LAST_COUNT = (IDX_WIDTH+1)'(N_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] PTR_ONE    = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(N_CLASSES - 1);

    snap_state_t           state;
    logic                  strobe_q;
    logic                  cap_ev;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  max_idx;
    logic [DATA_WIDTH-1:0] max_val;
    logic                  take_new;
    logic                  last_write;
    logic                  transfer;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Strict greater-than in the configured number domain; equality never
    // replaces the current maximum, which gives the lowest-index tie-break.
    function automatic logic is_greater(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // A capture event is either the rising edge of the strobe or simply the
    // strobe level. strobe_q clears on reset, so a strobe held through reset
    // counts once on the first cycle afterwards.
    assign cap_ev = (EDGE_DETECT != 0) ? (cap_strobe & ~strobe_q) : cap_strobe;

    // The first entry of a set always seeds the running maximum.
    assign take_new   = (count == '0) || is_greater(cap_data, max_val);
    assign last_write = (count == LAST_COUNT);
    assign transfer   = rd_valid && rd_ready;
    assign mem_we     = (state == COLLECT) && cap_ev && !clear;

    snapshot_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_CLASSES  (N_CLASSES),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count[IDX_WIDTH-1:0]),
        .wdata (cap_data),
        .raddr (ptr),
        .rdata (mem_rdata)
    );

    // The stream port is derived straight from the state flop so an
    // asynchronous reset drops rd_valid at once. rd_data is gated so the
    // uninitialised array never shows on the port while idle. Nothing on the
    // port changes during a stall because ptr only moves on a transfer and
    // the array is never written while streaming.
    assign rd_valid = (state == STREAM);
    assign rd_data  = rd_valid ? mem_rdata : '0;
    assign rd_index = ptr;
    assign rd_last  = rd_valid && (ptr == LAST_IDX);

    // Main controller. clear behaves exactly like reset but is sampled on the
    // clock and overrides anything else happening in that cycle. The final
    // capture moves to STREAM and publishes the argmax in the same edge, so
    // done and the result appear the cycle after the last strobe. Captures
    // arriving while streaming are dropped and flagged, including one that
    // coincides with the final transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            strobe_q   <= 1'b0;
            count      <= '0;
            ptr        <= '0;
            max_idx    <= '0;
            max_val    <= '0;
            done       <= 1'b0;
            argmax_idx <= '0;
            argmax_val <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= COLLECT;
            strobe_q   <= 1'b0;
            count      <= '0;
            ptr        <= '0;
            max_idx    <= '0;
            max_val    <= '0;
            done       <= 1'b0;
            argmax_idx <= '0;
            argmax_val <= '0;
            overflow   <= 1'b0;
        end else begin
            strobe_q <= cap_strobe;
            case (state)
                COLLECT: begin
                    if (cap_ev) begin
                        count <= count + CNT_ONE;
                        if (take_new) begin
                            max_val <= cap_data;
                            max_idx <= count[IDX_WIDTH-1:0];
                        end
                        if (last_write) begin
                            state      <= STREAM;
                            done       <= 1'b1;
                            argmax_idx <= take_new ? count[IDX_WIDTH-1:0] : max_idx;
                            argmax_val <= take_new ? cap_data : max_val;
                        end
                    end
                end
                STREAM: begin
                    if (cap_ev) begin
                        overflow <= 1'b1;
                    end
                    if (transfer) begin
                        if (ptr == LAST_IDX) begin
                            state <= COLLECT;
                            ptr   <= '0;
                            count <= '0;
                            done  <= 1'b0;
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
